// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared types and constants for the interrupt controller.
// Holds the FSM state encoding, register addresses and the ID width helper.
package int_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ASSERT  = 2'b01,
      SERVICE = 2'b10
   } state_t;

   localparam logic [1:0] ADDR_ENABLE  = 2'd0;
   localparam logic [1:0] ADDR_PENDING = 2'd1;
   localparam logic [1:0] ADDR_SWINT   = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: config bus plus core claim/complete handshake.
// master = core side (drives cfg_*, int_ack, int_done); slave = controller.
interface int_ctrl_if #(
   parameter int NUM_SRC = 8
);
   import int_ctrl_pkg::*;

   localparam int ID_W = id_width(NUM_SRC);

   logic            cfg_we;
   logic [1:0]      cfg_addr;
   logic [31:0]     cfg_wdata;
   logic [31:0]     cfg_rdata;
   logic            int_ack;
   logic            int_done;
   logic            ext_int;
   logic            sw_int;
   logic [ID_W-1:0] int_id;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata,
      output int_ack, int_done,
      input  cfg_rdata, ext_int, sw_int, int_id
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata,
      input  int_ack, int_done,
      output cfg_rdata, ext_int, sw_int, int_id
   );

endinterface

// File: rtl/int_ctrl_prio_enc.sv
// int_prio_enc: lowest-index-first priority encoder.
// Ports: req (request vector) -> any (some bit set), id (winning index).
module int_prio_enc
   import int_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = id_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               any,
   output logic [ID_W-1:0]    id
);

   // Scan from the top down so the lowest set index is written last.
   always_comb begin
      any = 1'b0;
      id  = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            any = 1'b1;
            id  = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: pending/enable interrupt controller with claim/complete FSM.
// Ports: clk, reset_n, irq_src, global_en, bus (int_ctrl_if.slave).
// Macro INT_CTRL_EDGE_EN selects rising-edge capture (default: level).
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               global_en,
   int_ctrl_if.slave          bus
);

   localparam int ID_W = id_width(NUM_SRC);

   state_t             state, state_nx;
   logic [ID_W-1:0]    sel_id, sel_nx;
   logic [ID_W-1:0]    int_id, int_id_nx;
   logic [NUM_SRC-1:0] enable, pending;
   logic [NUM_SRC-1:0] capture, cand, clr;
   logic               swint, any, claim;
   logic [ID_W-1:0]    cand_id;

`ifdef INT_CTRL_EDGE_EN
   logic [NUM_SRC-1:0] irq_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq_q <= '0;
      else          irq_q <= irq_src;
   end

   assign capture = irq_src & ~irq_q;
`else
   assign capture = irq_src;
`endif

   assign cand = pending & enable;

   int_prio_enc #(
      .NUM_SRC(NUM_SRC),
      .ID_W   (ID_W)
   ) u_enc (
      .req(cand),
      .any(any),
      .id (cand_id)
   );

   always_comb begin
      state_nx  = state;
      sel_nx    = sel_id;
      int_id_nx = int_id;
      claim     = 1'b0;
      case (state)
         IDLE: begin
            if (any && global_en) begin
               state_nx = ASSERT;
               sel_nx   = cand_id;
            end
         end
         ASSERT: begin
            // Track the candidate so a higher priority arrival preempts.
            sel_nx = cand_id;
            if (!any || !global_en) begin
               state_nx = IDLE;
            end else if (bus.int_ack) begin
               claim     = 1'b1;
               int_id_nx = sel_id;
               state_nx  = SERVICE;
            end
         end
         SERVICE: begin
            if (bus.int_done) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         sel_id <= '0;
         int_id <= '0;
      end else begin
         state  <= state_nx;
         sel_id <= sel_nx;
         int_id <= int_id_nx;
      end
   end

   // Clear sources: W1C write and claim; capture overrides both.
   always_comb begin
      clr = NUM_SRC'(claim) << sel_id;
      if (bus.cfg_we && bus.cfg_addr == ADDR_PENDING)
         clr = clr | bus.cfg_wdata[NUM_SRC-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable  <= '0;
         pending <= '0;
         swint   <= 1'b0;
      end else begin
         pending <= (pending & ~clr) | capture;
         if (bus.cfg_we && bus.cfg_addr == ADDR_ENABLE)
            enable <= bus.cfg_wdata[NUM_SRC-1:0];
         if (bus.cfg_we && bus.cfg_addr == ADDR_SWINT)
            swint <= bus.cfg_wdata[0];
      end
   end

   always_comb begin
      bus.cfg_rdata = '0;
      case (bus.cfg_addr)
         ADDR_ENABLE:  bus.cfg_rdata = 32'(enable);
         ADDR_PENDING: bus.cfg_rdata = 32'(pending);
         ADDR_SWINT:   bus.cfg_rdata = 32'(swint);
         ADDR_STATUS:  bus.cfg_rdata = 32'({state,
                                             state == SERVICE,
                                             state == ASSERT});
         default:      bus.cfg_rdata = '0;
      endcase
   end

   assign bus.ext_int = (state == ASSERT);
   assign bus.sw_int  = swint & global_en;
   assign bus.int_id  = int_id;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: self-checking bench for int_ctrl (register table plus
// hand-written claim sequences; claimed IDs go through a scoreboard queue).
module tb_int_ctrl;
   import int_ctrl_pkg::*;

   localparam int NSRC = 8;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [NSRC-1:0] irq_src;
   logic            global_en;

   int_ctrl_if #(.NUM_SRC(NSRC)) bus ();

   int_ctrl #(.NUM_SRC(NSRC)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .irq_src  (irq_src),
      .global_en(global_en),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic        gen;
      logic [31:0] exp_rd;
      logic        exp_sw;
   } vec_t;

   typedef struct {
      string       nm;
      logic [31:0] val;
   } exp_t;

   vec_t tbl[7];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push(input string nm, input logic [31:0] v);
      exp_t e;
      e.nm  = nm;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] act);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_underflow: got %h want none", act);
      end else begin
         e = sb.pop_front();
         chk(e.nm, act, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_wdata = d;
      tick();
      bus.cfg_we    = 1'b0;
      bus.cfg_wdata = '0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] e,
                     input string nm);
      bus.cfg_we   = 1'b0;
      bus.cfg_addr = a;
      #1;
      chk(nm, bus.cfg_rdata, e);
   endtask

   task automatic pulse(input int i);
      irq_src[i] = 1'b1;
      tick();
      irq_src[i] = 1'b0;
   endtask

   task automatic ack(input string nm, input logic [31:0] id);
      bus.int_ack = 1'b1;
      push(nm, id);
      tick();
      bus.int_ack = 1'b0;
      pop_chk(32'(bus.int_id));
   endtask

   task automatic done();
      bus.int_done = 1'b1;
      tick();
      bus.int_done = 1'b0;
   endtask

   initial begin
      tbl[0] = '{ADDR_ENABLE,  32'hFFFF_FF5A, 1'b1, 32'h5A, 1'b0};
      tbl[1] = '{ADDR_ENABLE,  32'hFFFF_FFFF, 1'b1, 32'hFF, 1'b0};
      tbl[2] = '{ADDR_SWINT,   32'hFFFF_FFFF, 1'b1, 32'h1,  1'b1};
      tbl[3] = '{ADDR_SWINT,   32'h1,         1'b0, 32'h1,  1'b0};
      tbl[4] = '{ADDR_SWINT,   32'h0,         1'b1, 32'h0,  1'b0};
      tbl[5] = '{ADDR_STATUS,  32'hF,         1'b1, 32'h0,  1'b0};
      tbl[6] = '{ADDR_ENABLE,  32'h0,         1'b1, 32'h0,  1'b0};

      reset_n       = 1'b0;
      irq_src       = '0;
      global_en     = 1'b0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_wdata = '0;
      bus.int_ack   = 1'b0;
      bus.int_done  = 1'b0;
      tick();
      tick();

      chk("rst_ext", 32'(bus.ext_int), 0);
      chk("rst_sw", 32'(bus.sw_int), 0);
      chk("rst_id", 32'(bus.int_id), 0);
      rd(ADDR_STATUS, 0, "rst_status");
      rd(ADDR_PENDING, 0, "rst_pending");
      reset_n = 1'b1;
      tick();

      // Register table: write, then read back next cycle.
      for (int i = 0; i < 7; i++) begin
         global_en = tbl[i].gen;
         wr(tbl[i].addr, tbl[i].wdata);
         push($sformatf("tbl%0d_rd", i), tbl[i].exp_rd);
         bus.cfg_addr = tbl[i].addr;
         #1;
         pop_chk(bus.cfg_rdata);
         chk($sformatf("tbl%0d_sw", i), 32'(bus.sw_int),
             32'(tbl[i].exp_sw));
      end
      global_en = 1'b1;

      // Basic latency: pend N+1, ext N+2, claim.
      wr(ADDR_ENABLE, 32'h01);
      pulse(0);
      rd(ADDR_PENDING, 32'h01, "lat_pend");
      chk("lat_ext_n1", 32'(bus.ext_int), 0);
      tick();
      chk("lat_ext_n2", 32'(bus.ext_int), 1);
      tick();
      tick();
      ack("lat_id", 0);
      chk("lat_ext_off", 32'(bus.ext_int), 0);
      rd(ADDR_PENDING, 0, "lat_pend_clr");
      rd(ADDR_STATUS, 32'hA, "lat_status_svc");
      done();
      rd(ADDR_STATUS, 0, "lat_status_idle");

      // Preemption: 5 then 2 while asserting.
      wr(ADDR_ENABLE, 32'hFF);
      pulse(5);
      tick();
      chk("pre_ext", 32'(bus.ext_int), 1);
      pulse(2);
      tick();
      ack("pre_id", 2);
      rd(ADDR_PENDING, 32'h20, "pre_pend");
      done();
      wr(ADDR_ENABLE, 0);
      wr(ADDR_PENDING, 32'h20);
      tick();
      chk("pre_clean_ext", 32'(bus.ext_int), 0);
      rd(ADDR_PENDING, 0, "pre_clean_pend");

      // Global enable gating.
      global_en = 1'b0;
      wr(ADDR_ENABLE, 32'h08);
      pulse(3);
      tick();
      tick();
      chk("gate_off", 32'(bus.ext_int), 0);
      rd(ADDR_PENDING, 32'h08, "gate_pend");
      global_en = 1'b1;
      tick();
      tick();
      chk("gate_on", 32'(bus.ext_int), 1);
      ack("gate_id", 3);
      done();

      // No claims while in SERVICE; ack ignored there.
      wr(ADDR_ENABLE, 32'hFF);
      pulse(0);
      tick();
      ack("svc_id0", 0);
      pulse(1);
      tick();
      tick();
      chk("svc_no_ext", 32'(bus.ext_int), 0);
      rd(ADDR_PENDING, 32'h02, "svc_pend");
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      chk("svc_ack_ign", 32'(bus.int_id), 0);
      rd(ADDR_PENDING, 32'h02, "svc_ack_pend");
      rd(ADDR_STATUS, 32'hA, "svc_status");
      done();
      chk("done_d1", 32'(bus.ext_int), 0);
      tick();
      chk("done_d2", 32'(bus.ext_int), 1);
      ack("svc_id1", 1);
      done();

      // W1C colliding with a new capture: set wins.
      wr(ADDR_ENABLE, 0);
      pulse(6);
      tick();
      rd(ADDR_PENDING, 32'h40, "w1c_pre");
      irq_src[6] = 1'b1;
      wr(ADDR_PENDING, 32'h40);
      irq_src[6] = 1'b0;
      rd(ADDR_PENDING, 32'h40, "w1c_set_wins");
      wr(ADDR_PENDING, 32'h40);
      rd(ADDR_PENDING, 0, "w1c_clear");

      // Enable dropped for the only candidate withdraws the request.
      wr(ADDR_ENABLE, 32'h01);
      pulse(0);
      tick();
      chk("en_drop_pre", 32'(bus.ext_int), 1);
      wr(ADDR_ENABLE, 0);
      tick();
      chk("en_drop", 32'(bus.ext_int), 0);
      wr(ADDR_PENDING, 32'h01);
      rd(ADDR_PENDING, 0, "en_drop_clr");

      // Source held high through the claim.
      wr(ADDR_ENABLE, 32'h10);
      irq_src[4] = 1'b1;
      tick();
      tick();
      chk("hold_ext", 32'(bus.ext_int), 1);
      ack("hold_id", 4);
      chk("hold_ext_off", 32'(bus.ext_int), 0);
      tick();
`ifdef INT_CTRL_EDGE_EN
      rd(ADDR_PENDING, 0, "hold_pend");
`else
      rd(ADDR_PENDING, 32'h10, "hold_pend");
`endif
      irq_src[4] = 1'b0;
      wr(ADDR_ENABLE, 0);
      wr(ADDR_PENDING, 32'h10);
      done();

      // Asynchronous reset in the middle of ASSERT.
      wr(ADDR_SWINT, 1);
      chk("rst2_sw_pre", 32'(bus.sw_int), 1);
      wr(ADDR_ENABLE, 32'h01);
      pulse(0);
      tick();
      chk("rst2_ext_pre", 32'(bus.ext_int), 1);
      #1 reset_n = 1'b0;
      #1;
      chk("rst2_ext", 32'(bus.ext_int), 0);
      chk("rst2_sw", 32'(bus.sw_int), 0);
      chk("rst2_id", 32'(bus.int_id), 0);
      rd(ADDR_ENABLE, 0, "rst2_enable");
      reset_n = 1'b1;
      tick();
      tick();
      chk("rst2_ext_post", 32'(bus.ext_int), 0);

      chk("sb_empty", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
